// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine: Ethernet CRC-32 over a framed byte stream, DATA_BYTES bytes per beat.
// A frame is delimited by SOF/EOF. The FCS is registered and presented one cycle after EOF.
// CRC_Ok flags the good-residue pattern, which is used to verify the FCS of received frames.
module crc32_stream_engine #(
    parameter int unsigned DATA_BYTES = 4,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE    = 32'h2144DF1C
) (
    input  logic                      Clk_125_MHz,
    input  logic                      Rst,
    input  logic                      In_Valid,
    input  logic                      In_SOF,
    input  logic                      In_EOF,
    input  logic [8*DATA_BYTES-1:0]   In_Data,
    input  logic [DATA_BYTES-1:0]     In_Keep,
    output logic                      Busy,
    output logic                      Out_Valid,
    output logic [31:0]               CRC_out,
    output logic                      CRC_Ok,
    output logic                      Frame_Err
);

    localparam int unsigned DATA_W = 8 * DATA_BYTES;
    localparam int unsigned CNT_W  = $clog2(DATA_BYTES + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Mirror a 32-bit word; the reflected LFSR shifts right with the reversed generator.
    function automatic logic [31:0] reverse32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] POLY_REV = reverse32(POLY);

    // Length of the leading run of ones in the byte enables; bytes after the first hole are ignored.
    function automatic logic [CNT_W-1:0] keep_count(input logic [DATA_BYTES-1:0] keep);
        logic [CNT_W-1:0] cnt;
        logic             run;
        cnt = '0;
        run = 1'b1;
        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            run = run & keep[k];
            if (run) begin
                cnt = cnt + CNT_W'(1);
            end
        end
        return cnt;
    endfunction

    // Fold the first nbytes bytes of a beat into the CRC, byte 0 first and each byte LSB first.
    function automatic logic [31:0] crc_update(input logic [31:0]      crc_in,
                                               input logic [DATA_W-1:0] data,
                                               input logic [CNT_W-1:0]  nbytes);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            if (k < 32'(nbytes)) begin
                for (int unsigned b = 0; b < 8; b++) begin
                    fb = c[0] ^ data[8*k+b];
                    c  = {1'b0, c[31:1]} ^ (fb ? POLY_REV : 32'h0000_0000);
                end
            end
        end
        return c;
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      crc_q;
    logic [31:0]      crc_d;
    logic             out_valid_d;
    logic             frame_err_d;
    logic [31:0]      crc_out_d;
    logic             crc_ok_d;
    logic             accept;
    logic [CNT_W-1:0] beat_len;
    logic [31:0]      beat_crc;
    logic [31:0]      fcs;

    // Next-state, CRC accumulation and next output values.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        crc_out_d   = CRC_out;
        crc_ok_d    = CRC_Ok;
        accept      = 1'b0;

        // An SOF beat always restarts from the preset, which also covers an abort.
        beat_len = In_EOF ? keep_count(In_Keep) : CNT_W'(DATA_BYTES);
        beat_crc = crc_update(In_SOF ? INIT : crc_q, In_Data, beat_len);
        fcs      = beat_crc ^ XOR_OUT;

        if (In_Valid) begin
            case (state_q)
                IDLE: begin
                    if (In_SOF) begin
                        accept = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                ACCUM: begin
                    accept = 1'b1;
                    if (In_SOF) begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (accept) begin
                if (In_EOF) begin
                    state_d     = IDLE;
                    crc_d       = INIT;
                    out_valid_d = 1'b1;
                    crc_out_d   = fcs;
                    crc_ok_d    = (fcs == RESIDUE);
                end else begin
                    state_d = ACCUM;
                    crc_d   = beat_crc;
                end
            end
        end
    end

    // State, CRC register and registered outputs.
    always_ff @(posedge Clk_125_MHz) begin
        if (Rst) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            Busy      <= 1'b0;
            Out_Valid <= 1'b0;
            CRC_out   <= 32'h0000_0000;
            CRC_Ok    <= 1'b0;
            Frame_Err <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            Busy      <= (state_d == ACCUM);
            Out_Valid <= out_valid_d;
            CRC_out   <= crc_out_d;
            CRC_Ok    <= crc_ok_d;
            Frame_Err <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_crc32_stream_engine.sv
// tb_crc32_stream_engine: bench for crc32_stream_engine (DATA_BYTES 4, plus 1 and 8 instances).
// Uses directed vector tables, hand-written corner sequences and random frames checked against a byte-table CRC model.
module tb_crc32_stream_engine;

    typedef logic [7:0] bytes_t[$];

    typedef struct {
        string       name;
        bit          v;
        bit          sof;
        bit          eof;
        logic [31:0] data;
        logic [3:0]  keep;
        bit          e_ov;
        bit          e_busy;
        bit          e_err;
        int          chk;     // 0: none, 1: CRC_Ok, 2: CRC_Ok and CRC_out
        logic [31:0] e_crc;
        bit          e_ok;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_keep = '0;
    logic        busy, out_valid, crc_ok, frame_err;
    logic [31:0] crc_out;

    logic        v1 = 1'b0, s1 = 1'b0, e1 = 1'b0;
    logic [7:0]  d1 = '0;
    logic [0:0]  k1 = '0;
    logic        b1, ov1, ok1, er1;
    logic [31:0] c1;

    logic        v8 = 1'b0, s8 = 1'b0, e8 = 1'b0;
    logic [63:0] d8 = '0;
    logic [7:0]  k8 = '0;
    logic        b8, ov8, ok8, er8;
    logic [31:0] c8;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] crc_tab[256];
    logic [31:0] last_crc;
    vec_t        tbl[$];

    always #4 clk = ~clk;

    crc32_stream_engine #(.DATA_BYTES(4)) dut (
        .Clk_125_MHz(clk), .Rst(rst), .In_Valid(in_valid), .In_SOF(in_sof), .In_EOF(in_eof),
        .In_Data(in_data), .In_Keep(in_keep), .Busy(busy), .Out_Valid(out_valid),
        .CRC_out(crc_out), .CRC_Ok(crc_ok), .Frame_Err(frame_err));

    crc32_stream_engine #(.DATA_BYTES(1)) dut1 (
        .Clk_125_MHz(clk), .Rst(rst), .In_Valid(v1), .In_SOF(s1), .In_EOF(e1),
        .In_Data(d1), .In_Keep(k1), .Busy(b1), .Out_Valid(ov1),
        .CRC_out(c1), .CRC_Ok(ok1), .Frame_Err(er1));

    crc32_stream_engine #(.DATA_BYTES(8)) dut8 (
        .Clk_125_MHz(clk), .Rst(rst), .In_Valid(v8), .In_SOF(s8), .In_EOF(e8),
        .In_Data(d8), .In_Keep(k8), .Busy(b8), .Out_Valid(ov8),
        .CRC_out(c8), .CRC_Ok(ok8), .Frame_Err(er8));

    // Standard byte-at-a-time table for the reflected CRC-32.
    task automatic build_table();
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
    endtask

    // Reference FCS of a byte string (preset all ones, final complement).
    function automatic logic [31:0] ref_crc(input bytes_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) c = crc_tab[(c ^ {24'h0, q[i]}) & 32'hFF] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input bit ov, input bit bsy, input bit err,
                              input int chk, input logic [31:0] crc, input bit ok);
        cmp({nm, ".Out_Valid"}, 32'(out_valid), 32'(ov));
        cmp({nm, ".Busy"}, 32'(busy), 32'(bsy));
        cmp({nm, ".Frame_Err"}, 32'(frame_err), 32'(err));
        if (chk >= 1) cmp({nm, ".CRC_Ok"}, 32'(crc_ok), 32'(ok));
        if (chk >= 2) cmp({nm, ".CRC_out"}, crc_out, crc);
    endtask

    task automatic step(input bit v, input bit s, input bit e, input logic [31:0] d, input logic [3:0] k);
        in_valid = v; in_sof = s; in_eof = e; in_data = d; in_keep = k;
        @(posedge clk); #1;
    endtask

    task automatic add(input string nm, input bit v, input bit s, input bit e, input logic [31:0] d,
                       input logic [3:0] k, input bit ov, input bit bsy, input bit err, input int chk,
                       input logic [31:0] crc, input bit ok);
        vec_t t;
        t = '{name: nm, v: v, sof: s, eof: e, data: d, keep: k, e_ov: ov, e_busy: bsy,
              e_err: err, chk: chk, e_crc: crc, e_ok: ok};
        tbl.push_back(t);
    endtask

    // Drive one frame with optional gaps and a garbage-tailed EOF keep; checks every cycle.
    task automatic send_frame(input string nm, input bytes_t q, input int gap_pct,
                              input bit empty_eof, input bit err_first);
        int          n, nb, r;
        bit          last;
        logic [31:0] d;
        logic [3:0]  k;
        logic [31:0] exp;
        n   = q.size();
        nb  = empty_eof ? (n / 4 + 1) : ((n + 3) / 4);
        exp = ref_crc(q);
        for (int b = 0; b < nb; b++) begin
            d = $urandom();
            for (int j = 0; j < 4; j++) if (4*b + j < n) d[8*j +: 8] = q[4*b + j];
            last = (b == nb - 1);
            k    = 4'hF;
            if (last) begin
                r = n - 4*b;
                if (r < 4) k = 4'((1 << r) - 1) | (4'($urandom()) & ~4'((2 << r) - 1));
            end
            step(1'b1, b == 0, last, d, k);
            if (last) begin
                expect_out({nm, ".eof"}, 1'b1, 1'b0, err_first && b == 0, 2, exp,
                           exp == 32'h2144DF1C);
                last_crc = exp;
            end else begin
                expect_out({nm, ".beat"}, 1'b0, 1'b1, err_first && b == 0, 0, '0, 1'b0);
                while ($urandom_range(99) < 32'(gap_pct)) begin
                    step(1'b0, 1'b0, 1'b0, $urandom(), 4'($urandom()));
                    expect_out({nm, ".gap"}, 1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
                end
            end
        end
    endtask

    function automatic bytes_t rand_bytes(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom()));
        return q;
    endfunction

    initial begin
        bytes_t      qa, qb;
        logic [31:0] f;
        logic [7:0]  s9[9];
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        build_table();

        // Reset state, with frame-like input ignored while Rst is high
        step(1'b1, 1'b1, 1'b1, 32'h12345678, 4'hF);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        expect_out("reset", 1'b0, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        rst = 1'b0;

        // Directed vectors: results are visible in the cycle after each beat
        add("s1_b0",   1,1,0, 32'h34333231, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("s1_b1",   1,0,0, 32'h38373635, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("s1_eof",  1,0,1, 32'h00000039, 4'h1, 1,0,0, 2, 32'hCBF43926, 0);
        add("s1_hold", 0,0,0, 32'h0,        4'h0, 0,0,0, 2, 32'hCBF43926, 0);
        add("s2_zero", 1,1,1, 32'h00000000, 4'h1, 1,0,0, 2, 32'hD202EF8D, 0);
        add("s3_b0",   1,1,0, 32'h34333231, 4'hF, 0,1,0, 2, 32'hD202EF8D, 0);
        add("s3_b1",   1,0,0, 32'h38373635, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("s3_b2",   1,0,0, 32'hF4392639, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("s3_eof",  1,0,1, 32'h000000CB, 4'h1, 1,0,0, 2, 32'h2144DF1C, 1);
        add("s3x_b0",  1,1,0, 32'h35333231, 4'hF, 0,1,0, 2, 32'h2144DF1C, 1);
        add("s3x_b1",  1,0,0, 32'h38373635, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("s3x_b2",  1,0,0, 32'hF4392639, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("s3x_eof", 1,0,1, 32'h000000CB, 4'h1, 1,0,0, 1, 32'h0, 0);
        add("nosof",   1,0,0, 32'hDEADBEEF, 4'hF, 0,0,1, 0, 32'h0, 0);
        add("nosof_e", 1,0,1, 32'hDEADBEEF, 4'h3, 0,0,1, 0, 32'h0, 0);
        add("quiet",   0,0,0, 32'h0,        4'h0, 0,0,0, 0, 32'h0, 0);
        add("k_b0",    1,1,0, 32'h34333231, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("k_gap",   0,0,0, 32'hFFFFFFFF, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("k_b1",    1,0,0, 32'h38373635, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("k_hole",  1,0,1, 32'hAABBCC39, 4'hD, 1,0,0, 2, 32'hCBF43926, 0);
        add("k0_sof",  1,1,0, 32'h34333231, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("k0_b1",   1,0,0, 32'h38373635, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("k0_b2",   1,0,0, 32'h55555539, 4'hF, 0,1,0, 0, 32'h0, 0);
        add("k0_eof",  1,0,1, 32'h01020304, 4'h0, 1,0,0, 1, 32'h0, 0);
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].sof, tbl[i].eof, tbl[i].data, tbl[i].keep);
            expect_out(tbl[i].name, tbl[i].e_ov, tbl[i].e_busy, tbl[i].e_err,
                       tbl[i].chk, tbl[i].e_crc, tbl[i].e_ok);
        end
        // EOF with Keep=0: same FCS as the 12 accumulated bytes
        qa = {};
        for (int i = 0; i < 9; i++) qa.push_back(s9[i]);
        qa.push_back(8'h55); qa.push_back(8'h55); qa.push_back(8'h55);
        cmp("k0_eof.CRC_out", crc_out, ref_crc(qa));
        step(1'b0, 1'b0, 1'b0, '0, '0);

        // Back-to-back frames, gaps inside the second one
        send_frame("b2b_1", rand_bytes(11), 0, 1'b0, 1'b0);
        send_frame("b2b_2", rand_bytes(17), 60, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        expect_out("b2b_idle", 1'b0, 1'b0, 1'b0, 2, last_crc, 1'b0);

        // SOF in the middle of a frame aborts it
        step(1'b1, 1'b1, 1'b0, $urandom(), 4'hF);
        expect_out("abort_b0", 1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, $urandom(), 4'hF);
        expect_out("abort_b1", 1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
        send_frame("abort_f2", rand_bytes(10), 20, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, $urandom(), 4'hF);
        expect_out("abort1b_b0", 1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
        send_frame("abort_1beat", rand_bytes(3), 0, 1'b0, 1'b1);

        // Reset in the middle of a frame discards it
        step(1'b1, 1'b1, 1'b0, $urandom(), 4'hF);
        step(1'b1, 1'b0, 1'b0, $urandom(), 4'hF);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1, $urandom(), 4'hF);
        expect_out("rst_mid", 1'b0, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0, '0);
        expect_out("rst_after", 1'b0, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        send_frame("rst_new", rand_bytes(9), 10, 1'b0, 1'b0);

        // Random frames, including check-mode frames carrying their own FCS
        for (int t = 0; t < 40; t++) begin
            if (t % 8 == 3) begin
                qb = rand_bytes($urandom_range(1, 30));
                f  = ref_crc(qb);
                for (int j = 0; j < 4; j++) qb.push_back(f[8*j +: 8]);
                send_frame("rnd_chk", qb, $urandom_range(0, 30), 1'b0, 1'b0);
            end else if (t % 5 == 1) begin
                send_frame("rnd_k0", rand_bytes(4 * $urandom_range(1, 8)), 20, 1'b1, 1'b0);
            end else begin
                send_frame("rnd", rand_bytes($urandom_range(1, 40)), $urandom_range(0, 30), 1'b0, 1'b0);
            end
            repeat ($urandom_range(0, 2)) begin
                step(1'b0, 1'b0, 1'b0, $urandom(), 4'($urandom()));
                expect_out("rnd_idle", 1'b0, 1'b0, 1'b0, 2, last_crc, last_crc == 32'h2144DF1C);
            end
        end

        // "123456789" with one byte per beat
        for (int i = 0; i < 9; i++) begin
            v1 = 1'b1; s1 = (i == 0); e1 = (i == 8); d1 = s9[i]; k1 = 1'b1;
            @(posedge clk); #1;
            if (i < 8) cmp("db1.Out_Valid_early", 32'(ov1), 32'h0);
        end
        v1 = 1'b0;
        cmp("db1.Out_Valid", 32'(ov1), 32'h1);
        cmp("db1.CRC_out", c1, 32'hCBF43926);
        cmp("db1.Busy", 32'(b1), 32'h0);

        // "123456789" with eight bytes per beat
        v8 = 1'b1; s8 = 1'b1; e8 = 1'b0; d8 = 64'h3837363534333231; k8 = 8'hFF;
        @(posedge clk); #1;
        cmp("db8.Busy", 32'(b8), 32'h1);
        s8 = 1'b0; e8 = 1'b1; d8 = 64'hA5A5A5A5A5A5A539; k8 = 8'hF9;
        @(posedge clk); #1;
        v8 = 1'b0;
        cmp("db8.Out_Valid", 32'(ov8), 32'h1);
        cmp("db8.CRC_out", c8, 32'hCBF43926);
        @(posedge clk); #1;
        cmp("db8.Out_Valid_pulse", 32'(ov8), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
